// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the priority interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKED
  } state_t;

  localparam logic [1:0] REG_IMR     = 2'd0;
  localparam logic [1:0] REG_IRR     = 2'd1;
  localparam logic [1:0] REG_ISR     = 2'd2;
  localparam logic [1:0] REG_VEC_EOI = 2'd3;

  localparam int unsigned EOI_NONSPEC = 3;

  localparam logic [15:0] SPURIOUS_VEC_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/prio_enc8.sv
// 8-bit priority encoder: reports the index of the lowest set bit.
module prio_enc8 (
  input  logic [7:0] in,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = |in;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int unsigned i = 8; i > 0; i--) begin
      if (in[i-1]) idx = 3'(i - 1);
    end
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Eight-input fixed-priority interrupt controller with edge capture, masking,
// in-service nesting, INT/intack handshake and a 4-word register block.
module irq_priority_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 8,
  parameter logic [15:0] VEC_BASE     = 16'h0000,
  parameter logic [15:0] SPURIOUS_VEC = SPURIOUS_VEC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               INT,
  input  logic               intack,
  input  logic               sel,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [15:0]        din,
  output logic [15:0]        dout
);

  logic [NUM_IRQ-1:0] imr, irr, isr, irq_prev;
  logic [15:0]        vector;
  state_t             state, state_d;

  logic [NUM_IRQ-1:0] higher_mask, eligible;
  logic               elig_valid, isr_valid;
  logic [2:0]         winner, isr_top;
  logic               grant, spurious;
  logic               imr_wr, eoi_wr;
  logic [NUM_IRQ-1:0] irr_d, isr_d;
  logic               unused_din;

  assign unused_din = ^din[15:NUM_IRQ];

  prio_enc8 u_enc_isr (
    .in    (isr),
    .valid (isr_valid),
    .idx   (isr_top)
  );

  // Only levels strictly above the highest one in service may interrupt.
  assign higher_mask = isr_valid ? ((NUM_IRQ'(1) << isr_top) - NUM_IRQ'(1)) : '1;
  assign eligible    = irr & ~imr & higher_mask;

  prio_enc8 u_enc_win (
    .in    (eligible),
    .valid (elig_valid),
    .idx   (winner)
  );

  assign imr_wr = sel && we && (addr == REG_IMR);
  assign eoi_wr = sel && we && (addr == REG_VEC_EOI);

  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    spurious = 1'b0;
    unique case (state)
      IDLE: begin
        spurious = intack;
        if (elig_valid) state_d = REQ;
      end
      REQ: begin
        if (intack && elig_valid) begin
          grant   = 1'b1;
          state_d = ACKED;
        end else if (!elig_valid) begin
          spurious = intack;
          state_d  = IDLE;
        end
      end
      ACKED: begin
        spurious = intack;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge set is applied after the grant clear so a fresh edge survives it;
  // ISR clears from EOI first, then the grant set overrides on the same bit.
  always_comb begin
    irr_d = irr;
    if (grant) irr_d[winner] = 1'b0;
    irr_d = irr_d | (irq & ~irq_prev);

    isr_d = isr;
    if (eoi_wr) begin
      if (din[EOI_NONSPEC]) begin
        if (isr_valid) isr_d[isr_top] = 1'b0;
      end else begin
        isr_d[din[2:0]] = 1'b0;
      end
    end
    if (grant) isr_d[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imr      <= '1;
      irr      <= '0;
      isr      <= '0;
      irq_prev <= '0;
      vector   <= SPURIOUS_VEC;
      state    <= IDLE;
      INT      <= 1'b0;
    end else begin
      irq_prev <= irq;
      irr      <= irr_d;
      isr      <= isr_d;
      state    <= state_d;
      INT      <= (state_d == REQ);
      if (imr_wr) imr <= din[NUM_IRQ-1:0];
      if (grant) begin
        vector <= VEC_BASE + 16'(winner);
      end else if (spurious) begin
        vector <= SPURIOUS_VEC;
      end
    end
  end

  always_comb begin
    dout = '0;
    if (sel) begin
      unique case (addr)
        REG_IMR:     dout = 16'(imr);
        REG_IRR:     dout = 16'(irr);
        REG_ISR:     dout = 16'(isr);
        REG_VEC_EOI: dout = vector;
        default:     dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed table-driven bench for irq_priority_ctrl plus a mid-handshake reset sequence.
module tb_irq_priority_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        irq_int;
  logic        intack;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [15:0] din;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  irq;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] din;
    logic        ack;
    logic        exp_int;
    logic [7:0]  exp_imr;
    logic [7:0]  exp_irr;
    logic [7:0]  exp_isr;
    logic [15:0] exp_vec;
  } vec_t;

  vec_t vecs[$];

  irq_priority_ctrl #(
    .NUM_IRQ      (8),
    .VEC_BASE     (16'h0000),
    .SPURIOUS_VEC (16'hFFFF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .irq    (irq),
    .INT    (irq_int),
    .intack (intack),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .din    (din),
    .dout   (dout)
  );

  always #10 clk = ~clk;

  task automatic add(input logic [7:0] i, input logic w, input logic [1:0] a,
                     input logic [15:0] d, input logic k, input logic ei,
                     input logic [7:0] em, input logic [7:0] er,
                     input logic [7:0] es, input logic [15:0] ev);
    vec_t v;
    v.irq = i; v.wr = w; v.addr = a; v.din = d; v.ack = k;
    v.exp_int = ei; v.exp_imr = em; v.exp_irr = er; v.exp_isr = es; v.exp_vec = ev;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 v = dout;
    sel = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic ei, input logic [7:0] em,
                           input logic [7:0] er, input logic [7:0] es, input logic [15:0] ev);
    logic [15:0] v;
    cmp({tag, " INT"}, 16'(irq_int), 16'(ei));
    rd(2'd0, v); cmp({tag, " IMR"}, v, 16'(em));
    rd(2'd1, v); cmp({tag, " IRR"}, v, 16'(er));
    rd(2'd2, v); cmp({tag, " ISR"}, v, 16'(es));
    rd(2'd3, v); cmp({tag, " VEC"}, v, ev);
  endtask

  task automatic step(input logic [7:0] i, input logic w, input logic [1:0] a,
                      input logic [15:0] d, input logic k);
    @(negedge clk);
    irq = i; sel = w; we = w; addr = a; din = d; intack = k;
    @(posedge clk);
    #1 sel = 1'b0; we = 1'b0; intack = 1'b0; din = '0;
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1; irq = '0; intack = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; din = '0;

    // irq, wr, addr, din, ack | INT, IMR, IRR, ISR, VECTOR
    add(8'h00, 1, 2'd0, 16'h00FB, 0,  0, 8'hFB, 8'h00, 8'h00, 16'hFFFF);
    add(8'h04, 0, 2'd0, 16'h0000, 0,  0, 8'hFB, 8'h04, 8'h00, 16'hFFFF);
    add(8'h04, 0, 2'd0, 16'h0000, 0,  1, 8'hFB, 8'h04, 8'h00, 16'hFFFF);
    add(8'h04, 0, 2'd0, 16'h0000, 1,  0, 8'hFB, 8'h00, 8'h04, 16'h0002);
    add(8'h04, 0, 2'd0, 16'h0000, 0,  0, 8'hFB, 8'h00, 8'h04, 16'h0002);
    add(8'h04, 0, 2'd0, 16'h0000, 0,  0, 8'hFB, 8'h00, 8'h04, 16'h0002);
    add(8'h00, 0, 2'd0, 16'h0000, 0,  0, 8'hFB, 8'h00, 8'h04, 16'h0002);
    add(8'h00, 1, 2'd3, 16'h0008, 0,  0, 8'hFB, 8'h00, 8'h00, 16'h0002);
    add(8'h00, 1, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h00, 16'h0002);
    add(8'h22, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h22, 8'h00, 16'h0002);
    add(8'h22, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h22, 8'h00, 16'h0002);
    add(8'h22, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h20, 8'h02, 16'h0001);
    add(8'h22, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h20, 8'h02, 16'h0001);
    add(8'h22, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h20, 8'h00, 16'h0001);
    add(8'h22, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h20, 8'h00, 16'h0001);
    add(8'h22, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h00, 8'h20, 16'h0005);
    add(8'h00, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h20, 16'h0005);
    add(8'h00, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00, 16'h0005);
    add(8'h10, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h10, 8'h00, 16'h0005);
    add(8'h10, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h10, 8'h00, 16'h0005);
    add(8'h10, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h00, 8'h10, 16'h0004);
    add(8'h10, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h10, 16'h0004);
    add(8'h11, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h01, 8'h10, 16'h0004);
    add(8'h11, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h01, 8'h10, 16'h0004);
    add(8'h11, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h00, 8'h11, 16'h0000);
    add(8'h11, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h10, 16'h0000);
    add(8'h00, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h10, 16'h0000);
    add(8'h00, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00, 16'h0000);
    add(8'h08, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h08, 8'h00, 16'h0000);
    add(8'h08, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h08, 8'h00, 16'h0000);
    add(8'h08, 1, 2'd0, 16'h0008, 0,  1, 8'h08, 8'h08, 8'h00, 16'h0000);
    add(8'h08, 0, 2'd0, 16'h0000, 0,  0, 8'h08, 8'h08, 8'h00, 16'h0000);
    add(8'h08, 1, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h08, 8'h00, 16'h0000);
    add(8'h08, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h08, 8'h00, 16'h0000);
    add(8'h08, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h00, 8'h08, 16'h0003);
    add(8'h00, 1, 2'd3, 16'h0003, 0,  0, 8'h00, 8'h00, 8'h00, 16'h0003);
    add(8'h00, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    add(8'h00, 1, 2'd3, 16'h0006, 0,  0, 8'h00, 8'h00, 8'h00, 16'hFFFF);
    add(8'h40, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h40, 8'h00, 16'hFFFF);
    add(8'h40, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h40, 8'h00, 16'hFFFF);
    add(8'h40, 1, 2'd0, 16'h00FF, 1,  0, 8'hFF, 8'h00, 8'h40, 16'h0006);
    add(8'h40, 1, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h40, 16'h0006);
    add(8'h00, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00, 16'h0006);
    add(8'h80, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h80, 8'h00, 16'h0006);
    add(8'h00, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h80, 8'h00, 16'h0006);
    add(8'h80, 0, 2'd0, 16'h0000, 1,  0, 8'h00, 8'h80, 8'h80, 16'h0007);
    add(8'h80, 0, 2'd0, 16'h0000, 0,  0, 8'h00, 8'h80, 8'h80, 16'h0007);
    add(8'h00, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h80, 8'h00, 16'h0007);
    add(8'h00, 0, 2'd0, 16'h0000, 0,  1, 8'h00, 8'h80, 8'h00, 16'h0007);
    add(8'h00, 1, 2'd3, 16'h0007, 1,  0, 8'h00, 8'h00, 8'h80, 16'h0007);
    add(8'h00, 1, 2'd1, 16'h00FF, 0,  0, 8'h00, 8'h00, 8'h80, 16'h0007);
    add(8'h00, 1, 2'd2, 16'h00FF, 0,  0, 8'h00, 8'h00, 8'h80, 16'h0007);
    add(8'h00, 1, 2'd3, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00, 16'h0007);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset", 1'b0, 8'hFF, 8'h00, 8'h00, 16'hFFFF);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].irq, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].ack);
      check_all($sformatf("v%0d", i), vecs[i].exp_int, vecs[i].exp_imr,
                vecs[i].exp_irr, vecs[i].exp_isr, vecs[i].exp_vec);
    end

    // Reset asserted in REQ together with intack: reset must win.
    step(8'h02, 1'b0, 2'd0, 16'h0000, 1'b0);
    step(8'h02, 1'b0, 2'd0, 16'h0000, 1'b0);
    cmp("pre_rst INT", 16'(irq_int), 16'h0001);
    @(negedge clk);
    rst = 1'b1; intack = 1'b1; irq = '0;
    @(posedge clk);
    #1 intack = 1'b0;
    check_all("rst_in_req", 1'b0, 8'hFF, 8'h00, 8'h00, 16'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0; addr = 2'd0;
    #1 cmp("dout_unselected", dout, 16'h0000);
    sel = 1'b1;
    #1 v = dout;
    sel = 1'b0;
    cmp("dout_selected_imr", v, 16'h00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
